// File: rtl/axi_ram_responder_if.sv
// AXI3 bus bundle between the no-cache master and the RAM responder.
// The master modport drives requests and write data; the slave modport drives ready/response.
interface axi_ram_responder_if #(
  parameter int unsigned ID_W = 4
);
  logic [ID_W-1:0] arid;
  logic [31:0]     araddr;
  logic [3:0]      arlen;
  logic [1:0]      arburst;
  logic            arvalid;
  logic            arready;
  logic [ID_W-1:0] rid;
  logic [31:0]     rdata;
  logic [1:0]      rresp;
  logic            rlast;
  logic            rvalid;
  logic            rready;
  logic [ID_W-1:0] awid;
  logic [31:0]     awaddr;
  logic [3:0]      awlen;
  logic [1:0]      awburst;
  logic            awvalid;
  logic            awready;
  logic [31:0]     wdata;
  logic [3:0]      wstrb;
  logic            wlast;
  logic            wvalid;
  logic            wready;
  logic [ID_W-1:0] bid;
  logic [1:0]      bresp;
  logic            bvalid;
  logic            bready;

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    output awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  arready, rid, rdata, rresp, rlast, rvalid,
    input  awready, wready, bid, bresp, bvalid
  );

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    input  awid, awaddr, awlen, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output arready, rid, rdata, rresp, rlast, rvalid,
    output awready, wready, bid, bresp, bvalid
  );
endinterface

// File: rtl/axi_ram_responder.sv
// AXI3 slave RAM model with independent read and write FSMs, FIXED/INCR/WRAP bursts
// and a programmable read latency.
module axi_ram_responder #(
  parameter int unsigned ID_W       = 4,
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned RD_LAT     = 2
) (
  input logic                clk,
  input logic                rst,
  axi_ram_responder_if.slave bus
);

  localparam int unsigned IdxW  = DEPTH_LOG2;
  localparam int unsigned Words = 2 ** DEPTH_LOG2;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;

  typedef enum logic [1:0] {RIdle, RWait, RData} r_state_e;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;

  logic [31:0] mem [Words];

  // Word index of the following beat; WRAP keeps the upper index bits and wraps the low ones.
  function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] idx,
                                               input logic [3:0]      len,
                                               input logic [1:0]      burst);
    logic [IdxW-1:0] mask;
    logic [IdxW-1:0] inc;
    mask = IdxW'(len);
    inc  = idx + 1'b1;
    if (burst == BurstFixed) begin
      return idx;
    end else if (burst == BurstWrap &&
                 (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)) begin
      return (idx & ~mask) | (inc & mask);
    end
    return inc;
  endfunction

  // Read channel
  r_state_e        r_state;
  logic [3:0]      r_cnt;
  logic [IdxW-1:0] r_idx;
  logic [3:0]      r_len;
  logic [1:0]      r_burst;
  logic [3:0]      r_beat;
  logic [ID_W-1:0] rid_q;
  logic [31:0]     rdata_q;
  logic [1:0]      rresp_q;
  logic            rlast_q;
  logic            rvalid_q;
  logic [IdxW-1:0] ar_idx;
  logic [IdxW-1:0] r_nidx;

  assign ar_idx = bus.araddr[DEPTH_LOG2+1:2];
  assign r_nidx = next_idx(r_idx, r_len, r_burst);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= RIdle;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_len    <= '0;
      r_burst  <= '0;
      r_beat   <= '0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
      rvalid_q <= 1'b0;
    end else begin
      unique case (r_state)
        RIdle: begin
          if (bus.arvalid) begin
            rid_q   <= bus.arid;
            r_idx   <= ar_idx;
            r_len   <= bus.arlen;
            r_burst <= bus.arburst;
            r_beat  <= '0;
            rresp_q <= (bus.arburst == BurstRsvd) ? RespSlvErr : RespOkay;
            if (RD_LAT == 1) begin
              rdata_q  <= (bus.arburst == BurstRsvd) ? 32'h0 : mem[ar_idx];
              rlast_q  <= (bus.arlen == 4'd0);
              rvalid_q <= 1'b1;
              r_state  <= RData;
            end else begin
              r_cnt   <= 4'(RD_LAT - 1);
              r_state <= RWait;
            end
          end
        end
        RWait: begin
          if (r_cnt == 4'd1) begin
            rdata_q  <= (r_burst == BurstRsvd) ? 32'h0 : mem[r_idx];
            rlast_q  <= (r_len == 4'd0);
            rvalid_q <= 1'b1;
            r_state  <= RData;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RData: begin
          if (bus.rready) begin
            if (rlast_q) begin
              rvalid_q <= 1'b0;
              rlast_q  <= 1'b0;
              r_state  <= RIdle;
            end else begin
              r_idx   <= r_nidx;
              rdata_q <= (r_burst == BurstRsvd) ? 32'h0 : mem[r_nidx];
              r_beat  <= r_beat + 4'd1;
              rlast_q <= ((r_beat + 4'd1) == r_len);
            end
          end
        end
        default: r_state <= RIdle;
      endcase
    end
  end

  assign bus.arready = (r_state == RIdle);
  assign bus.rid     = rid_q;
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.rlast   = rlast_q;
  assign bus.rvalid  = rvalid_q;

  // Write channel
  w_state_e        w_state;
  logic [IdxW-1:0] w_idx;
  logic [3:0]      w_len;
  logic [1:0]      w_burst;
  logic [3:0]      w_beat;
  logic            w_err;
  logic [ID_W-1:0] bid_q;
  logic [1:0]      bresp_q;
  logic            bvalid_q;
  logic            w_we;

  assign w_we = (w_state == WData) && bus.wvalid && (w_burst != BurstRsvd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state  <= WIdle;
      w_idx    <= '0;
      w_len    <= '0;
      w_burst  <= '0;
      w_beat   <= '0;
      w_err    <= 1'b0;
      bid_q    <= '0;
      bresp_q  <= '0;
      bvalid_q <= 1'b0;
    end else begin
      unique case (w_state)
        WIdle: begin
          if (bus.awvalid) begin
            bid_q   <= bus.awid;
            w_idx   <= bus.awaddr[DEPTH_LOG2+1:2];
            w_len   <= bus.awlen;
            w_burst <= bus.awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_state <= WData;
          end
        end
        WData: begin
          if (bus.wvalid) begin
            w_idx <= next_idx(w_idx, w_len, w_burst);
            if (w_beat != 4'd15) begin
              w_beat <= w_beat + 4'd1;
            end
            if (bus.wlast) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (w_burst == BurstRsvd || w_err || w_beat != w_len) ?
                          RespSlvErr : RespOkay;
              w_state  <= WResp;
            end else if (w_beat == w_len) begin
              // Sticky so a late wlast is flagged even once the counter saturates.
              w_err <= 1'b1;
            end
          end
        end
        WResp: begin
          if (bus.bready) begin
            bvalid_q <= 1'b0;
            w_state  <= WIdle;
          end
        end
        default: w_state <= WIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int b = 0; b < 4; b++) begin
        if (bus.wstrb[b]) begin
          mem[w_idx][8*b +: 8] <= bus.wdata[8*b +: 8];
        end
      end
    end
  end

  assign bus.awready = (w_state == WIdle);
  assign bus.wready  = (w_state == WData);
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.bvalid  = bvalid_q;

  logic unused_addr;
  assign unused_addr = ^{bus.araddr[31:DEPTH_LOG2+2], bus.araddr[1:0],
                         bus.awaddr[31:DEPTH_LOG2+2], bus.awaddr[1:0]};

endmodule

// File: tb/tb_axi_ram_responder.sv
// Directed self-checking bench for axi_ram_responder (ID_W=4, DEPTH_LOG2=12, RD_LAT=2).
module tb_axi_ram_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wbuf  [16];
  logic [31:0] rbuf  [16];
  logic [1:0]  rrbuf [16];
  logic        rlbuf [16];

  always #5 clk = ~clk;

  axi_ram_responder_if #(.ID_W(4)) bus ();

  axi_ram_responder #(
    .ID_W      (4),
    .DEPTH_LOG2(12),
    .RD_LAT    (2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [3:0] len,
                           input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                           input logic [3:0] strb, output logic [1:0] resp,
                           output logic [3:0] got_bid);
    int t;
    resp        = 2'b11;
    got_bid     = 4'h0;
    bus.awaddr  = addr;
    bus.awlen   = len;
    bus.awburst = burst;
    bus.awid    = id;
    bus.awvalid = 1'b1;
    t = 0;
    while (!bus.awready && t < 50) begin tick(); t++; end
    tick();
    bus.awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      bus.wdata  = wbuf[i];
      bus.wstrb  = strb;
      bus.wlast  = (i == nbeats - 1);
      bus.wvalid = 1'b1;
      t = 0;
      while (!bus.wready && t < 50) begin tick(); t++; end
      tick();
    end
    bus.wvalid = 1'b0;
    bus.wlast  = 1'b0;
    t = 0;
    while (!bus.bvalid && t < 50) begin tick(); t++; end
    if (!bus.bvalid) begin
      checks++; errors++;
      $display("FAIL b_timeout got bvalid=%b exp 1", bus.bvalid);
    end
    resp       = bus.bresp;
    got_bid    = bus.bid;
    bus.bready = 1'b1;
    tick();
    bus.bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] id, input int nbeats,
                          output logic [3:0] got_rid);
    int t;
    got_rid     = 4'h0;
    bus.araddr  = addr;
    bus.arlen   = len;
    bus.arburst = burst;
    bus.arid    = id;
    bus.arvalid = 1'b1;
    t = 0;
    while (!bus.arready && t < 50) begin tick(); t++; end
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    for (int i = 0; i < nbeats; i++) begin
      t = 0;
      while (!bus.rvalid && t < 50) begin tick(); t++; end
      if (!bus.rvalid) begin
        checks++; errors++;
        $display("FAIL r_timeout beat %0d got rvalid=%b exp 1", i, bus.rvalid);
        break;
      end
      rbuf[i]  = bus.rdata;
      rrbuf[i] = bus.rresp;
      rlbuf[i] = bus.rlast;
      got_rid  = bus.rid;
      tick();
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL rst_arready got %b exp 1", bus.arready); end
    checks++; if (bus.awready !== 1'b1) begin errors++; $display("FAIL rst_awready got %b exp 1", bus.awready); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid got %b exp 0", bus.rvalid); end
    checks++; if (bus.bvalid !== 1'b0) begin errors++; $display("FAIL rst_bvalid got %b exp 0", bus.bvalid); end
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL rst_wready got %b exp 0", bus.wready); end
    checks++; if (bus.rlast !== 1'b0) begin errors++; $display("FAIL rst_rlast got %b exp 0", bus.rlast); end
    checks++; if (bus.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata got %h exp 0", bus.rdata); end
    checks++;
    if ({bus.rid, bus.bid, bus.rresp, bus.bresp} !== 12'h0) begin
      errors++;
      $display("FAIL rst_ids got %h exp 000", {bus.rid, bus.bid, bus.rresp, bus.bresp});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_w_before_aw();
    bus.wdata  = 32'hCAFE0000;
    bus.wstrb  = 4'hF;
    bus.wvalid = 1'b1;
    tick();
    checks++; if (bus.wready !== 1'b0) begin errors++; $display("FAIL early_w_wready got %b exp 0", bus.wready); end
    bus.wvalid = 1'b0;
    tick();
  endtask

  task automatic test_single_read();
    logic [1:0] resp;
    logic [3:0] b;
    wbuf[0] = 32'hDEADBEEF;
    axi_write(32'h40, 4'd0, 2'b01, 4'h3, 1, 4'hF, resp, b);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL preload_bresp got %b exp 00", resp); end
    bus.araddr = 32'h40; bus.arlen = 4'd0; bus.arburst = 2'b01; bus.arid = 4'hA;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL lat_t1_rvalid got %b exp 0", bus.rvalid); end
    tick();
    checks++; if (bus.rvalid !== 1'b1) begin errors++; $display("FAIL lat_t2_rvalid got %b exp 1", bus.rvalid); end
    checks++; if (bus.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_rdata got %h exp deadbeef", bus.rdata); end
    checks++; if (bus.rlast !== 1'b1) begin errors++; $display("FAIL single_rlast got %b exp 1", bus.rlast); end
    checks++; if (bus.rresp !== 2'b00) begin errors++; $display("FAIL single_rresp got %b exp 00", bus.rresp); end
    checks++; if (bus.rid !== 4'hA) begin errors++; $display("FAIL single_rid got %h exp a", bus.rid); end
    bus.rready = 1'b1;
    tick();
    bus.rready = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL single_end_rvalid got %b exp 0", bus.rvalid); end
    checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL single_end_arready got %b exp 1", bus.arready); end
  endtask

  task automatic test_burst_write();
    logic [1:0]  resp;
    logic [3:0]  b;
    logic [3:0]  r;
    logic [31:0] exp_d [4];
    exp_d[0] = 32'h11; exp_d[1] = 32'h22; exp_d[2] = 32'h33; exp_d[3] = 32'h44;
    for (int i = 0; i < 4; i++) wbuf[i] = exp_d[i];
    axi_write(32'h100, 4'd3, 2'b01, 4'h5, 4, 4'hF, resp, b);
    checks++; if (resp !== 2'b00) begin errors++; $display("FAIL burst_bresp got %b exp 00", resp); end
    checks++; if (b !== 4'h5) begin errors++; $display("FAIL burst_bid got %h exp 5", b); end
    axi_read(32'h100, 4'd3, 2'b01, 4'h9, 4, r);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rbuf[i] !== exp_d[i]) begin
        errors++; $display("FAIL burst_rdata beat %0d got %h exp %h", i, rbuf[i], exp_d[i]);
      end
    end
    checks++;
    if ({rlbuf[3], rlbuf[2], rlbuf[1], rlbuf[0]} !== 4'b1000) begin
      errors++;
      $display("FAIL burst_rlast got %b exp 1000", {rlbuf[3], rlbuf[2], rlbuf[1], rlbuf[0]});
    end
    checks++; if (r !== 4'h9) begin errors++; $display("FAIL burst_rid got %h exp 9", r); end
  endtask

  task automatic test_wrap_stall();
    int t;
    bus.araddr = 32'h108; bus.arlen = 4'd3; bus.arburst = 2'b10; bus.arid = 4'h1;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    t = 0;
    while (!bus.rvalid && t < 50) begin tick(); t++; end
    checks++; if (bus.rdata !== 32'h33) begin errors++; $display("FAIL wrap_b0 got %h exp 33", bus.rdata); end
    tick();
    bus.rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h44 || bus.rlast !== 1'b0) begin
        errors++;
        $display("FAIL wrap_stall cyc %0d got v=%b d=%h l=%b exp v=1 d=44 l=0",
                 i, bus.rvalid, bus.rdata, bus.rlast);
      end
      tick();
    end
    bus.rready = 1'b1;
    tick();
    checks++; if (bus.rdata !== 32'h11) begin errors++; $display("FAIL wrap_b2 got %h exp 11", bus.rdata); end
    tick();
    checks++;
    if (bus.rdata !== 32'h22 || bus.rlast !== 1'b1) begin
      errors++; $display("FAIL wrap_b3 got d=%h l=%b exp d=22 l=1", bus.rdata, bus.rlast);
    end
    tick();
    bus.rready = 1'b0;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL wrap_end got %b exp 0", bus.rvalid); end
  endtask

  task automatic test_strobe();
    logic [1:0] resp;
    logic [3:0] b;
    logic [3:0] r;
    wbuf[0] = 32'h12345678;
    axi_write(32'h200, 4'd0, 2'b01, 4'h2, 1, 4'hF, resp, b);
    wbuf[0] = 32'hAABBCCDD;
    axi_write(32'h200, 4'd0, 2'b01, 4'h2, 1, 4'b0101, resp, b);
    axi_read(32'h200, 4'd0, 2'b01, 4'h2, 1, r);
    checks++; if (rbuf[0] !== 32'h12BB56DD) begin errors++; $display("FAIL strobe got %h exp 12bb56dd", rbuf[0]); end
  endtask

  task automatic test_fixed();
    logic [1:0] resp;
    logic [3:0] b;
    logic [3:0] r;
    wbuf[0] = 32'h0000_0001; wbuf[1] = 32'h0000_0002;
    axi_write(32'h500, 4'd1, 2'b00, 4'h4, 2, 4'hF, resp, b);
    axi_read(32'h500, 4'd1, 2'b01, 4'h4, 2, r);
    checks++;
    if (rbuf[0] !== 32'h2) begin errors++; $display("FAIL fixed_w0 got %h exp 2", rbuf[0]); end
    checks++;
    if (resp !== 2'b00) begin errors++; $display("FAIL fixed_bresp got %b exp 00", resp); end
  endtask

  task automatic test_wlast_mismatch();
    logic [1:0] resp;
    logic [3:0] b;
    logic [3:0] r;
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hFFFFFFFF;
    axi_write(32'h300, 4'd3, 2'b01, 4'h6, 4, 4'hF, resp, b);
    wbuf[0] = 32'hA1; wbuf[1] = 32'hA2;
    axi_write(32'h300, 4'd3, 2'b01, 4'h6, 2, 4'hF, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL early_wlast_bresp got %b exp 10", resp); end
    axi_read(32'h300, 4'd3, 2'b01, 4'h6, 4, r);
    checks++;
    if (rbuf[0] !== 32'hA1 || rbuf[1] !== 32'hA2 || rbuf[2] !== 32'hFFFFFFFF ||
        rbuf[3] !== 32'hFFFFFFFF) begin
      errors++;
      $display("FAIL early_wlast_data got %h %h %h %h exp a1 a2 ffffffff ffffffff",
               rbuf[0], rbuf[1], rbuf[2], rbuf[3]);
    end
    wbuf[0] = 32'hB1; wbuf[1] = 32'hB2;
    axi_write(32'h600, 4'd0, 2'b01, 4'h7, 2, 4'hF, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL late_wlast_bresp got %b exp 10", resp); end
    axi_read(32'h604, 4'd0, 2'b01, 4'h7, 1, r);
    checks++; if (rbuf[0] !== 32'hB2) begin errors++; $display("FAIL late_wlast_data got %h exp b2", rbuf[0]); end
  endtask

  task automatic test_reserved();
    logic [1:0] resp;
    logic [3:0] b;
    logic [3:0] r;
    wbuf[0] = 32'h77;
    axi_write(32'h400, 4'd0, 2'b01, 4'h1, 1, 4'hF, resp, b);
    wbuf[0] = 32'h55;
    axi_write(32'h400, 4'd0, 2'b11, 4'h1, 1, 4'hF, resp, b);
    checks++; if (resp !== 2'b10) begin errors++; $display("FAIL rsvd_bresp got %b exp 10", resp); end
    axi_read(32'h400, 4'd1, 2'b11, 4'h1, 2, r);
    checks++;
    if (rrbuf[0] !== 2'b10 || rrbuf[1] !== 2'b10) begin
      errors++; $display("FAIL rsvd_rresp got %b %b exp 10 10", rrbuf[0], rrbuf[1]);
    end
    checks++;
    if (rbuf[0] !== 32'h0 || rbuf[1] !== 32'h0) begin
      errors++; $display("FAIL rsvd_rdata got %h %h exp 0 0", rbuf[0], rbuf[1]);
    end
    checks++; if (rlbuf[1] !== 1'b1) begin errors++; $display("FAIL rsvd_rlast got %b exp 1", rlbuf[1]); end
    axi_read(32'h400, 4'd0, 2'b01, 4'h1, 1, r);
    checks++; if (rbuf[0] !== 32'h77) begin errors++; $display("FAIL rsvd_nowrite got %h exp 77", rbuf[0]); end
  endtask

  task automatic test_reset_mid_read();
    int t;
    logic [3:0] r;
    bus.araddr = 32'h100; bus.arlen = 4'd3; bus.arburst = 2'b01; bus.arid = 4'h2;
    bus.arvalid = 1'b1;
    tick();
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    t = 0;
    while (!bus.rvalid && t < 50) begin tick(); t++; end
    tick();
    bus.rready = 1'b0;
    checks++;
    if (bus.rvalid !== 1'b1 || bus.rdata !== 32'h22) begin
      errors++; $display("FAIL midrst_beat2 got v=%b d=%h exp v=1 d=22", bus.rvalid, bus.rdata);
    end
    rst = 1'b1;
    #1;
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL midrst_rvalid got %b exp 0", bus.rvalid); end
    tick(); tick();
    rst = 1'b0;
    tick();
    checks++; if (bus.arready !== 1'b1) begin errors++; $display("FAIL midrst_arready got %b exp 1", bus.arready); end
    checks++; if (bus.rvalid !== 1'b0) begin errors++; $display("FAIL midrst_idle_rvalid got %b exp 0", bus.rvalid); end
    axi_read(32'h40, 4'd0, 2'b01, 4'hC, 1, r);
    checks++;
    if (rbuf[0] !== 32'hDEADBEEF || rrbuf[0] !== 2'b00 || r !== 4'hC) begin
      errors++;
      $display("FAIL midrst_newread got d=%h resp=%b id=%h exp deadbeef 00 c", rbuf[0], rrbuf[0], r);
    end
  endtask

  initial begin
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arburst = '0; bus.arvalid = 1'b0;
    bus.rready = 1'b0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awburst = '0; bus.awvalid = 1'b0;
    bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0; bus.bready = 1'b0;
    test_reset();
    test_w_before_aw();
    test_single_read();
    test_burst_write();
    test_wrap_stall();
    test_strobe();
    test_fixed();
    test_wlast_mismatch();
    test_reserved();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
